// File: rtl/path_delay_probe.sv
// Launch/capture controller for one instrumented delay path: toggles the path input, times the
// synchronised return level in clk cycles, and keeps min/max/sum latency over a run of trials.
//
// state  | meaning
// IDLE   | waiting for start; results of the last run held
// ARM    | waiting for the path output to sit at the current launch level
// LAUNCH | toggle the path input, restart the latency count
// WAIT   | counting cycles until the new level comes back (or TIMEOUT)
// SETTLE | quiet gap so the path fully quiesces before the next trial
// FINISH | one-cycle done pulse, then back to IDLE
module path_delay_probe #(
    parameter int INVERT     = 0,
    parameter int CNT_W      = 8,
    parameter int TRIAL_W    = 8,
    parameter int TIMEOUT    = 200,
    parameter int SETTLE_CYC = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [TRIAL_W-1:0]       i_trials,
    output logic                     o_path_launch,
    input  logic                     i_path_capture,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_timeout_err,
    output logic [CNT_W-1:0]         o_lat_min,
    output logic [CNT_W-1:0]         o_lat_max,
    output logic [CNT_W+TRIAL_W-1:0] o_lat_sum
);

    localparam int SUM_W     = CNT_W + TRIAL_W;
    localparam int SETTLE_LD = (SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0;

    localparam logic [CNT_W-1:0]   TMO_VAL   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]   TMO_M1    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   SETTLE_M1 = CNT_W'(SETTLE_LD);
    localparam logic [TRIAL_W-1:0] ONE_TRIAL = TRIAL_W'(1);
    localparam logic               INV_B     = (INVERT != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_SETTLE = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next;

    logic               r_sync1;
    logic               r_cap_s;
    logic               r_path_launch;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_tmr;
    logic [TRIAL_W-1:0] r_left;
    logic               r_timeout_err;
    logic [CNT_W-1:0]   r_lat_min;
    logic [CNT_W-1:0]   r_lat_max;
    logic [SUM_W-1:0]   r_lat_sum;

    logic               w_expected;
    logic               w_match;
    logic               w_start_ok;
    logic               w_tmr_tc;
    logic               w_wait_tc;
    logic               w_record;
    logic               w_wait_expire;
    logic               w_arm_expire;
    logic               w_enter_arm;
    logic               w_enter_settle;
    logic               w_more_trials;
    logic [CNT_W-1:0]   w_rec_val;

    // Two-flop synchroniser; its two cycles are deliberately part of every measured latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_cap_s <= 1'b0;
        end else begin
            r_sync1 <= i_path_capture;
            r_cap_s <= r_sync1;
        end
    end

    assign w_expected     = r_path_launch ^ INV_B;
    assign w_match        = (r_cap_s == w_expected);
    assign w_start_ok     = (r_state == S_IDLE) && i_start;
    assign w_tmr_tc       = (r_tmr == '0);
    assign w_wait_tc      = (r_cnt == TMO_VAL);
    assign w_record       = (r_state == S_WAIT) && (w_match || w_wait_tc);
    assign w_wait_expire  = (r_state == S_WAIT) && !w_match && w_wait_tc;
    assign w_arm_expire   = (r_state == S_ARM) && !w_match && w_tmr_tc;
    assign w_rec_val      = w_match ? r_cnt : TMO_VAL;
    assign w_more_trials  = (r_left > ONE_TRIAL);
    assign w_enter_arm    = (w_next == S_ARM) && (r_state != S_ARM);
    assign w_enter_settle = (w_next == S_SETTLE) && (r_state != S_SETTLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_ARM;
                end
            end
            S_ARM: begin
                if (w_match) begin
                    w_next = S_LAUNCH;
                end else if (w_tmr_tc) begin
                    w_next = S_FINISH;
                end
            end
            S_LAUNCH: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_record) begin
                    w_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (w_tmr_tc) begin
                    w_next = w_more_trials ? S_ARM : S_FINISH;
                end
            end
            S_FINISH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // busy drops in FINISH so the host sees busy=0 together with the done pulse.
    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            S_IDLE:   o_busy = 1'b0;
            S_FINISH: o_done = 1'b1;
            default:  o_busy = 1'b1;
        endcase
    end

    // Shared down-counter: ARM timeout window and SETTLE gap never overlap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tmr <= '0;
        end else if (w_enter_arm) begin
            r_tmr <= TMO_M1;
        end else if (w_enter_settle) begin
            r_tmr <= SETTLE_M1;
        end else if (!w_tmr_tc) begin
            r_tmr <= r_tmr - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_LAUNCH) begin
            r_cnt <= CNT_W'(1);
        end else if ((r_state == S_WAIT) && !w_record) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Launch level is not cleared between runs, so consecutive trials alternate rise/fall.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_path_launch <= 1'b0;
        end else if (r_state == S_LAUNCH) begin
            r_path_launch <= ~r_path_launch;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_left <= '0;
        end else if (w_start_ok) begin
            r_left <= (i_trials == '0) ? ONE_TRIAL : i_trials;
        end else if ((r_state == S_SETTLE) && w_tmr_tc && w_more_trials) begin
            r_left <= r_left - ONE_TRIAL;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timeout_err <= 1'b0;
        end else if (w_start_ok) begin
            r_timeout_err <= 1'b0;
        end else if (w_wait_expire || w_arm_expire) begin
            r_timeout_err <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lat_min <= '1;
            r_lat_max <= '0;
            r_lat_sum <= '0;
        end else if (w_start_ok) begin
            r_lat_min <= '1;
            r_lat_max <= '0;
            r_lat_sum <= '0;
        end else if (w_record) begin
            if (w_rec_val < r_lat_min) begin
                r_lat_min <= w_rec_val;
            end
            if (w_rec_val > r_lat_max) begin
                r_lat_max <= w_rec_val;
            end
            r_lat_sum <= r_lat_sum + SUM_W'(w_rec_val);
        end
    end

    assign o_path_launch = r_path_launch;
    assign o_timeout_err = r_timeout_err;
    assign o_lat_min     = r_lat_min;
    assign o_lat_max     = r_lat_max;
    assign o_lat_sum     = r_lat_sum;

endmodule
